// File: rtl/sda_kernel_ctrl_regs.sv
// sda_kernel_ctrl_regs: host-facing ap_ctrl register block for the kernel action.
//   - Terminates the host AXI4-Lite control port (s_axi_*).
//   - Local registers at offsets below FWD_BASE:
//       0x00 CTRL (start W1S / done clear-on-read / idle / ready)
//       0x04 GIE, 0x08 IER, 0x0C ISR (W1C)
//   - Offsets at or above FWD_BASE are forwarded to the action's AXI-lite slave (m_axi_*),
//     rebased by FWD_BASE. At most one read and one write are outstanding.
//   - go_0r/go_0a and done_0r/done_0a are 4-phase handshakes with the action.
//   - interrupt is a level output: GIE & IER[0] & ISR[0].
// Ports: clk, reset (sync, active-high), s_axi_* host slave, m_axi_* action master,
//        go_0r/go_0a, done_0r/done_0a, interrupt.
module sda_kernel_ctrl_regs #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned FWD_BASE   = 'h10
) (
  input  logic                  clk,
  input  logic                  reset,
  // host read channel
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [31:0]           s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  // host write channel
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [31:0]           s_axi_wdata,
  input  logic [3:0]            s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  // action parameter port, read
  output logic [31:0]           m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  // action parameter port, write
  output logic [31:0]           m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // action handshakes
  output logic                  go_0r,
  input  logic                  go_0a,
  input  logic                  done_0r,
  output logic                  done_0a,
  output logic                  interrupt
);

  localparam logic [ADDR_WIDTH-1:0] AddrCtrl = ADDR_WIDTH'('h00);
  localparam logic [ADDR_WIDTH-1:0] AddrGie  = ADDR_WIDTH'('h04);
  localparam logic [ADDR_WIDTH-1:0] AddrIer  = ADDR_WIDTH'('h08);
  localparam logic [ADDR_WIDTH-1:0] AddrIsr  = ADDR_WIDTH'('h0C);

  typedef enum logic [2:0] {StIdle, StGoReq, StGoRel, StWaitDone, StDoneAck} act_state_e;
  typedef enum logic [2:0] {RdIdle, RdLocal, RdFwdAr, RdFwdR, RdResp} rd_state_e;
  typedef enum logic [2:0] {WrIdle, WrLocal, WrFwd, WrFwdB, WrResp} wr_state_e;

  act_state_e act_q;
  rd_state_e  rd_q;
  wr_state_e  wr_q;

  logic [ADDR_WIDTH-1:0] raddr_q, waddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  ap_done_q, ap_ready_q, gie_q, ier_q, isr_q;
  logic [31:0]           local_rdata;

  function automatic logic is_fwd(input logic [ADDR_WIDTH-1:0] a);
    return 32'(a) >= FWD_BASE;
  endfunction

  // Local register side effects happen in the cycle after the host handshake.
  logic wr_local, wr_ctrl, wr_gie, wr_ier, wr_isr, rd_ctrl, start_req, done_evt;
  assign wr_local  = (wr_q == WrLocal) && wstrb_q[0];
  assign wr_ctrl   = wr_local && (waddr_q == AddrCtrl);
  assign wr_gie    = wr_local && (waddr_q == AddrGie);
  assign wr_ier    = wr_local && (waddr_q == AddrIer);
  assign wr_isr    = wr_local && (waddr_q == AddrIsr);
  assign rd_ctrl   = (rd_q == RdLocal) && (raddr_q == AddrCtrl);
  assign start_req = wr_ctrl && wdata_q[0];
  assign done_evt  = (act_q == StWaitDone) && done_0r;

  assign interrupt   = gie_q & ier_q & isr_q;
  assign m_axi_wdata = wdata_q;
  assign m_axi_wstrb = wstrb_q;

  always_comb begin
    local_rdata = '0;
    case (raddr_q)
      AddrCtrl: local_rdata[3:0] = {ap_ready_q, act_q == StIdle, ap_done_q, act_q == StGoReq};
      AddrGie:  local_rdata[0]   = gie_q;
      AddrIer:  local_rdata[0]   = ier_q;
      AddrIsr:  local_rdata[0]   = isr_q;
      default:  ;
    endcase
  end

  // Action handshake FSM and local register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q      <= StIdle;
      go_0r      <= 1'b0;
      done_0a    <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_ready_q <= 1'b0;
      gie_q      <= 1'b0;
      ier_q      <= 1'b0;
      isr_q      <= 1'b0;
    end else begin
      ap_ready_q <= 1'b0;
      case (act_q)
        StIdle:     if (start_req) begin act_q <= StGoReq; go_0r <= 1'b1; end
        StGoReq:    if (go_0a) begin act_q <= StGoRel; go_0r <= 1'b0; end
        StGoRel:    if (!go_0a) act_q <= StWaitDone;
        StWaitDone: if (done_0r) begin
          act_q      <= StDoneAck;
          done_0a    <= 1'b1;
          ap_ready_q <= 1'b1;
        end
        StDoneAck:  if (!done_0r) begin act_q <= StIdle; done_0a <= 1'b0; end
        default:    act_q <= StIdle;
      endcase
      if (wr_gie) gie_q <= wdata_q[0];
      if (wr_ier) ier_q <= wdata_q[0];
      // Completion wins over a same-cycle clear.
      if (done_evt) ap_done_q <= 1'b1;
      else if (rd_ctrl) ap_done_q <= 1'b0;
      if (done_evt && ier_q) isr_q <= 1'b1;
      else if (wr_isr && wdata_q[0]) isr_q <= 1'b0;
    end
  end

  // Read path.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q          <= RdIdle;
      raddr_q       <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= 2'b00;
      s_axi_rvalid  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      s_axi_arready <= 1'b0;
      case (rd_q)
        RdIdle: if (s_axi_arvalid) begin
          s_axi_arready <= 1'b1;
          raddr_q       <= s_axi_araddr;
          if (is_fwd(s_axi_araddr)) begin
            rd_q          <= RdFwdAr;
            m_axi_araddr  <= 32'(s_axi_araddr) - FWD_BASE;
            m_axi_arvalid <= 1'b1;
          end else begin
            rd_q <= RdLocal;
          end
        end
        RdLocal: begin
          s_axi_rdata  <= local_rdata;
          s_axi_rresp  <= 2'b00;
          s_axi_rvalid <= 1'b1;
          rd_q         <= RdResp;
        end
        RdFwdAr: if (m_axi_arready) begin
          m_axi_arvalid <= 1'b0;
          m_axi_rready  <= 1'b1;
          rd_q          <= RdFwdR;
        end
        RdFwdR: if (m_axi_rvalid) begin
          m_axi_rready <= 1'b0;
          s_axi_rdata  <= m_axi_rdata;
          s_axi_rresp  <= m_axi_rresp;
          s_axi_rvalid <= 1'b1;
          rd_q         <= RdResp;
        end
        RdResp: if (s_axi_rready) begin
          s_axi_rvalid <= 1'b0;
          rd_q         <= RdIdle;
        end
        default: rd_q <= RdIdle;
      endcase
    end
  end

  // Write path.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q          <= WrIdle;
      waddr_q       <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bresp   <= 2'b00;
      s_axi_bvalid  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      case (wr_q)
        WrIdle: if (s_axi_awvalid && s_axi_wvalid) begin
          s_axi_awready <= 1'b1;
          s_axi_wready  <= 1'b1;
          waddr_q       <= s_axi_awaddr;
          wdata_q       <= s_axi_wdata;
          wstrb_q       <= s_axi_wstrb;
          if (is_fwd(s_axi_awaddr)) begin
            wr_q          <= WrFwd;
            m_axi_awaddr  <= 32'(s_axi_awaddr) - FWD_BASE;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
          end else begin
            wr_q <= WrLocal;
          end
        end
        WrLocal: begin
          s_axi_bresp  <= 2'b00;
          s_axi_bvalid <= 1'b1;
          wr_q         <= WrResp;
        end
        WrFwd: begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) m_axi_wvalid <= 1'b0;
          // Move on once both address and data have been taken, in either order.
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            wr_q         <= WrFwdB;
          end
        end
        WrFwdB: if (m_axi_bvalid) begin
          m_axi_bready <= 1'b0;
          s_axi_bresp  <= m_axi_bresp;
          s_axi_bvalid <= 1'b1;
          wr_q         <= WrResp;
        end
        WrResp: if (s_axi_bready) begin
          s_axi_bvalid <= 1'b0;
          wr_q         <= WrIdle;
        end
        default: wr_q <= WrIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_regs.sv
// Testbench for sda_kernel_ctrl_regs: directed scenarios plus a randomized mix of local
// register accesses, action runs and forwarded accesses, checked against a register-level model.
module tb_sda_kernel_ctrl_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] s_axi_araddr, s_axi_awaddr;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_rdata, s_axi_wdata;
  logic [1:0]  s_axi_rresp, s_axi_bresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic [3:0]  s_axi_wstrb, m_axi_wstrb;
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic        go_0r, go_0a, done_0r, done_0a, interrupt;

  always #5 clk = ~clk;

  sda_kernel_ctrl_regs #(.ADDR_WIDTH(12), .FWD_BASE('h10)) dut (
    .clk(clk), .reset(reset),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .go_0r(go_0r), .go_0a(go_0a), .done_0r(done_0r), .done_0a(done_0a), .interrupt(interrupt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Register-level reference model.
  bit m_gie, m_ier, m_isr, m_done;

  function automatic logic [31:0] exp_local(input logic [11:0] a, input bit busy);
    case (a)
      12'h000: return (busy ? 32'h0 : 32'h4) | (m_done ? 32'h2 : 32'h0);
      12'h004: return 32'(m_gie);
      12'h008: return 32'(m_ier);
      12'h00C: return 32'(m_isr);
      default: return 32'h0;
    endcase
  endfunction

  // Action responder: acks go after act_go_delay cycles, raises done after act_done_delay.
  int act_st = 0, act_cnt = 0, act_go_delay = 3, act_done_delay = 10;
  bit act_hold = 0;
  int go_count = 0, done_count = 0;
  bit go_prev = 0;

  always @(negedge clk) begin
    if (go_0r && !go_prev) go_count++;
    go_prev = go_0r;
  end

  always @(negedge clk) begin
    if (reset) begin
      act_st = 0; act_cnt = 0; go_0a = 1'b0; done_0r = 1'b0;
    end else begin
      case (act_st)
        0: if (go_0r && !act_hold) begin act_cnt = 0; act_st = 1; end
        1: begin act_cnt++; if (act_cnt >= act_go_delay) begin go_0a = 1'b1; act_st = 2; end end
        2: if (!go_0r) begin go_0a = 1'b0; act_cnt = 0; act_st = 3; end
        3: begin act_cnt++; if (act_cnt >= act_done_delay) begin done_0r = 1'b1; act_st = 4; end end
        4: if (done_0a) begin done_0r = 1'b0; act_st = 5; end
        5: if (!done_0a) begin done_count++; act_st = 0; end
        default: act_st = 0;
      endcase
    end
  end

  // Action AXI-lite slave with programmable delays; records what it was sent.
  int ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] rd_data_v;
  logic [1:0]  rd_resp_v, b_resp_v;
  logic [31:0] seen_araddr, seen_awaddr, seen_wdata;
  logic [3:0]  seen_wstrb;
  int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  bit r_pend, r_hs, aw_got, w_got, b_hs;

  always @(negedge clk) begin
    if (reset) begin
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
      ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      r_pend = 0; r_hs = 0; aw_got = 0; w_got = 0; b_hs = 0;
    end else begin
      // A ready raised while the DUT holds valid completes on the next edge.
      if (m_axi_arready) begin m_axi_arready = 0; r_pend = 1; r_cnt = 0; end
      else if (m_axi_arvalid) begin
        if (ar_cnt >= ar_delay) begin
          m_axi_arready = 1; seen_araddr = m_axi_araddr; ar_cnt = 0;
        end else ar_cnt++;
      end
      if (m_axi_rvalid) begin
        if (r_hs) begin m_axi_rvalid = 0; r_hs = 0; end
        else if (m_axi_rready) r_hs = 1;
      end else if (r_pend) begin
        if (r_cnt >= r_delay) begin
          m_axi_rvalid = 1; m_axi_rdata = rd_data_v; m_axi_rresp = rd_resp_v; r_pend = 0;
          if (m_axi_rready) r_hs = 1;
        end else r_cnt++;
      end
      if (m_axi_awready) m_axi_awready = 0;
      else if (m_axi_awvalid && !aw_got) begin
        if (aw_cnt >= aw_delay) begin
          m_axi_awready = 1; seen_awaddr = m_axi_awaddr; aw_got = 1; aw_cnt = 0;
        end else aw_cnt++;
      end
      if (m_axi_wready) m_axi_wready = 0;
      else if (m_axi_wvalid && !w_got) begin
        if (w_cnt >= w_delay) begin
          m_axi_wready = 1; seen_wdata = m_axi_wdata; seen_wstrb = m_axi_wstrb; w_got = 1; w_cnt = 0;
        end else w_cnt++;
      end
      if (m_axi_bvalid) begin
        if (b_hs) begin m_axi_bvalid = 0; b_hs = 0; end
        else if (m_axi_bready) b_hs = 1;
      end else if (aw_got && w_got && !m_axi_awready && !m_axi_wready) begin
        if (b_cnt >= b_delay) begin
          m_axi_bvalid = 1; m_axi_bresp = b_resp_v; aw_got = 0; w_got = 0; b_cnt = 0;
          if (m_axi_bready) b_hs = 1;
        end else b_cnt++;
      end
    end
  end

  // Host bus tasks.
  task automatic host_read(input logic [11:0] addr, input int rready_delay,
                           output logic [31:0] data, output logic [1:0] resp);
    int t;
    bit held;
    data = 'x; resp = 'x;
    @(negedge clk);
    s_axi_araddr = addr; s_axi_arvalid = 1; s_axi_rready = 0;
    t = 0;
    while (!s_axi_arready && t < 100) begin @(negedge clk); t++; end
    if (!s_axi_arready) begin
      check("arready_timeout", 32'(s_axi_arready), 32'h1); s_axi_arvalid = 0; return;
    end
    @(negedge clk); s_axi_arvalid = 0;
    t = 0;
    while (!s_axi_rvalid && t < 200) begin @(negedge clk); t++; end
    if (!s_axi_rvalid) begin check("rvalid_timeout", 32'(s_axi_rvalid), 32'h1); return; end
    held = 1;
    for (int i = 0; i < rready_delay; i++) begin @(negedge clk); if (!s_axi_rvalid) held = 0; end
    if (rready_delay > 0) check("rvalid_hold", 32'(held), 32'h1);
    data = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1;
    @(negedge clk); s_axi_rready = 0;
  endtask

  task automatic host_write(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int bready_delay, output logic [1:0] resp);
    int t;
    bit held;
    resp = 'x;
    @(negedge clk);
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_bready = 0;
    t = 0;
    while (!(s_axi_awready && s_axi_wready) && t < 100) begin @(negedge clk); t++; end
    if (!(s_axi_awready && s_axi_wready)) begin
      check("aw_w_accept_timeout", {30'b0, s_axi_awready, s_axi_wready}, 32'h3);
      s_axi_awvalid = 0; s_axi_wvalid = 0; return;
    end
    @(negedge clk); s_axi_awvalid = 0; s_axi_wvalid = 0;
    t = 0;
    while (!s_axi_bvalid && t < 200) begin @(negedge clk); t++; end
    if (!s_axi_bvalid) begin check("bvalid_timeout", 32'(s_axi_bvalid), 32'h1); return; end
    held = 1;
    for (int i = 0; i < bready_delay; i++) begin @(negedge clk); if (!s_axi_bvalid) held = 0; end
    if (bready_delay > 0) check("bvalid_hold", 32'(held), 32'h1);
    resp = s_axi_bresp;
    s_axi_bready = 1;
    @(negedge clk); s_axi_bready = 0;
  endtask

  task automatic local_read(input logic [11:0] a, input bit busy);
    logic [31:0] d;
    logic [1:0]  r;
    host_read(a, $urandom_range(0, 2), d, r);
    check($sformatf("rd_%03h", a), d, exp_local(a, busy));
    check("rd_local_resp", 32'(r), 32'h0);
    if (a == 12'h000) m_done = 0;
  endtask

  task automatic local_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r;
    host_write(a, d, s, $urandom_range(0, 2), r);
    check("wr_local_resp", 32'(r), 32'h0);
    if (s[0]) begin
      if (a == 12'h004) m_gie = d[0];
      if (a == 12'h008) m_ier = d[0];
      if (a == 12'h00C && d[0]) m_isr = 0;
    end
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_count == d0 && t < 500) begin @(negedge clk); t++; end
    if (done_count == d0) check("action_done_timeout", 32'(done_count), 32'(d0 + 1));
  endtask

  task automatic run_action(input int gd, input int dd);
    int g0 = go_count, d0 = done_count;
    act_go_delay = gd; act_done_delay = dd;
    local_write(12'h000, ($urandom() & 32'hFFFF_FFF0) | 32'h1, 4'h1 | 4'($urandom_range(0, 15)));
    wait_done(d0);
    check("go_once", 32'(go_count - g0), 32'h1);
    m_done = 1;
    if (m_ier) m_isr = 1;
    check("irq_after_action", 32'(interrupt), 32'(m_gie & m_ier & m_isr));
  endtask

  task automatic fwd_read(input logic [11:0] a, input logic [31:0] d, input logic [1:0] rs);
    logic [31:0] got;
    logic [1:0]  r;
    rd_data_v = d; rd_resp_v = rs;
    host_read(a, $urandom_range(0, 3), got, r);
    check("fwd_araddr", seen_araddr, 32'(a) - 32'h10);
    check("fwd_rdata", got, d);
    check("fwd_rresp", 32'(r), 32'(rs));
  endtask

  task automatic fwd_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] bs, input int bdly);
    logic [1:0] r;
    b_resp_v = bs;
    host_write(a, d, s, bdly, r);
    check("fwd_awaddr", seen_awaddr, 32'(a) - 32'h10);
    check("fwd_wdata", seen_wdata, d);
    check("fwd_wstrb", 32'(seen_wstrb), 32'(s));
    check("fwd_bresp", 32'(r), 32'(bs));
  endtask

  task automatic model_reset();
    m_gie = 0; m_ier = 0; m_isr = 0; m_done = 0;
  endtask

  initial begin
    int g0, d0, t;
    reset = 1;
    s_axi_araddr = '0; s_axi_arvalid = 0; s_axi_rready = 0;
    s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 0; s_axi_bready = 0;
    rd_data_v = '0; rd_resp_v = '0; b_resp_v = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_go_0r", 32'(go_0r), 32'h0);
    check("rst_done_0a", 32'(done_0a), 32'h0);
    check("rst_outputs", {26'b0, s_axi_arready, s_axi_rvalid, s_axi_awready, s_axi_bvalid,
                          m_axi_arvalid, m_axi_awvalid}, 32'h0);
    reset = 0;

    // 1: reset state.
    local_read(12'h000, 0);
    local_read(12'h00C, 0);
    check("irq_reset", 32'(interrupt), 32'h0);

    // 2: full go/done with interrupt.
    local_write(12'h004, 32'h1, 4'hF);
    local_write(12'h008, 32'h1, 4'hF);
    run_action(3, 10);
    check("irq_set", 32'(interrupt), 32'h1);
    local_read(12'h000, 0);
    local_read(12'h000, 0);
    local_write(12'h00C, 32'h1, 4'h1);
    check("irq_cleared", 32'(interrupt), 32'h0);

    // 3: start while busy is ignored.
    g0 = go_count; d0 = done_count;
    act_go_delay = 2; act_done_delay = 40;
    local_write(12'h000, 32'h1, 4'h1);
    t = 0;
    while (act_st != 3 && t < 100) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    local_read(12'h000, 1);
    local_write(12'h000, 32'h1, 4'h1);
    wait_done(d0);
    m_done = 1; m_isr = 1;
    repeat (20) @(negedge clk);
    check("busy_start_ignored", 32'(go_count - g0), 32'h1);
    check("one_completion", 32'(done_count - d0), 32'h1);

    // 4: forwarded read with slow arready and SLVERR.
    ar_delay = 5; r_delay = 1;
    fwd_read(12'h018, 32'hDEAD_BEEF, 2'b10);
    ar_delay = 0; r_delay = 0;

    // 5: forwarded write with partial strobes and slow bready.
    fwd_write(12'h020, 32'h1234_5678, 4'h5, 2'b00, 4);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0: local_write(12'(4 * $urandom_range(1, 3)), $urandom(), 4'($urandom_range(0, 15)));
        1: local_read(12'(4 * $urandom_range(0, 3)), 0);
        2: run_action($urandom_range(1, 4), $urandom_range(1, 12));
        3: begin
          ar_delay = $urandom_range(0, 4); r_delay = $urandom_range(0, 4);
          fwd_read(12'($urandom_range(16, 4095)), $urandom(), 2'($urandom_range(0, 3)));
        end
        4: begin
          aw_delay = $urandom_range(0, 4); w_delay = $urandom_range(0, 4);
          b_delay = $urandom_range(0, 3);
          fwd_write(12'($urandom_range(16, 4095)), $urandom(), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), $urandom_range(0, 3));
        end
        default: local_write(12'h000, $urandom() & 32'hFFFF_FFFE, 4'($urandom_range(0, 15)));
      endcase
      check("irq_model", 32'(interrupt), 32'(m_gie & m_ier & m_isr));
    end
    ar_delay = 0; r_delay = 0; aw_delay = 0; w_delay = 0; b_delay = 0;

    // 6a: reset while in GO_REQ.
    act_hold = 1;
    local_write(12'h000, 32'h1, 4'h1);
    t = 0;
    while (!go_0r && t < 20) begin @(negedge clk); t++; end
    check("go_req_seen", 32'(go_0r), 32'h1);
    reset = 1;
    @(negedge clk);
    check("rst_mid_go_0r", 32'(go_0r), 32'h0);
    check("rst_mid_irq", 32'(interrupt), 32'h0);
    reset = 0; act_hold = 0;
    model_reset();

    // 6b: reset during a forwarded read.
    ar_delay = 30;
    @(negedge clk);
    s_axi_araddr = 12'h018; s_axi_arvalid = 1;
    t = 0;
    while (!m_axi_arvalid && t < 20) begin @(negedge clk); t++; end
    check("fwd_ar_seen", 32'(m_axi_arvalid), 32'h1);
    reset = 1; s_axi_arvalid = 0;
    @(negedge clk);
    check("rst_mid_arvalid", 32'(m_axi_arvalid), 32'h0);
    check("rst_mid_rvalid", 32'(s_axi_rvalid), 32'h0);
    reset = 0; ar_delay = 0;
    local_read(12'h000, 0);
    local_read(12'h008, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
